// File: rtl/colour_fader.sv
// Per-channel colour fader: accepts a target colour and ramps the registered
// output toward it by STEP_SIZE every STEP_COUNTS clocks, feeding the PWM stage.
module colour_fader #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int FADE_STEP_HZ = 1_000,
  parameter int BIT_W        = 8,
  parameter int STEP_SIZE    = 1
) (
  input  logic             clk_in,
  input  logic             n_reset_in,
  input  logic [BIT_W-1:0] target_colour_in,
  input  logic             target_valid_in,
  output logic             target_ready_out,
  input  logic             abort_in,
  output logic [BIT_W-1:0] colour_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [1:0]       state_dbg_out
);

  localparam int STEP_COUNTS = SYS_CLK_FREQ / FADE_STEP_HZ;
  localparam int CNT_W       = $clog2(STEP_COUNTS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_COUNTS - 1);
  localparam logic [BIT_W:0]   STEP_EXT = (BIT_W + 1)'(STEP_SIZE);

  if (STEP_COUNTS < 1) begin : g_bad_step_counts
    $fatal(1, "colour_fader: SYS_CLK_FREQ / FADE_STEP_HZ must be at least 1");
  end
  if (STEP_SIZE < 1 || STEP_SIZE > (2 ** BIT_W) - 1) begin : g_bad_step_size
    $fatal(1, "colour_fader: STEP_SIZE must lie in 1 .. 2**BIT_W-1");
  end

  // Handshake: a target is taken on a rising edge where target_valid_in and
  // target_ready_out are both high; ready is high only in IDLE, so requests
  // made while fading are simply not taken and must be held by the upstream.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] target_q, target_d;
  logic [BIT_W-1:0] colour_q, colour_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;

  logic [BIT_W:0]   colour_ext, target_ext, up_sum, down_diff;
  logic [BIT_W-1:0] up_next, down_next, step_next;
  logic             down_underflow, cnt_last;
  logic             accept_equal, fade_complete, done_req;

  // Step arithmetic is one bit wider than the colour so neither direction wraps.
  always_comb begin
    colour_ext     = {1'b0, colour_q};
    target_ext     = {1'b0, target_q};
    up_sum         = colour_ext + STEP_EXT;
    down_diff      = colour_ext - STEP_EXT;
    down_underflow = down_diff[BIT_W];
    up_next        = (up_sum >= target_ext) ? target_q : up_sum[BIT_W-1:0];
    down_next      = (down_underflow || (down_diff <= target_ext)) ? target_q
                                                                   : down_diff[BIT_W-1:0];
    step_next      = (state_q == FADE_UP) ? up_next : down_next;
    cnt_last       = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_d      = target_q;
    colour_d      = colour_q;
    accept_equal  = 1'b0;
    fade_complete = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (target_valid_in) begin
          target_d = target_colour_in;
          cnt_d    = '0;
          if (target_colour_in > colour_q) begin
            state_d = FADE_UP;
          end else if (target_colour_in < colour_q) begin
            state_d = FADE_DOWN;
          end else begin
            accept_equal = 1'b1;
          end
        end
      end
      FADE_UP, FADE_DOWN: begin
        if (abort_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_last) begin
          cnt_d    = '0;
          colour_d = step_next;
          if (step_next == target_q) begin
            state_d       = IDLE;
            fade_complete = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A done request landing on the cycle right after a pulse is deferred one
  // cycle so done_out never stays high across two consecutive cycles.
  always_comb begin
    done_req = accept_equal | fade_complete | pend_q;
    done_d   = done_req & ~done_q;
    pend_d   = done_req & done_q;
  end

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      colour_q <= '0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      colour_q <= colour_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
    end
  end

  assign target_ready_out = (state_q == IDLE);
  assign busy_out         = (state_q != IDLE);
  assign colour_out       = colour_q;
  assign done_out         = done_q;
  assign state_dbg_out    = state_q;

endmodule

// File: tb/tb_colour_fader.sv
// Randomised scoreboard bench for colour_fader with a step-count reference model.
module tb_colour_fader;

  localparam int STEP_CNT = 4;
  localparam int STEP     = 16;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] target;
  logic       valid;
  logic       abort;
  logic       ready;
  logic [7:0] colour;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  colour_fader #(
    .SYS_CLK_FREQ(100),
    .FADE_STEP_HZ(25),
    .BIT_W(8),
    .STEP_SIZE(STEP)
  ) dut (
    .clk_in(clk),
    .n_reset_in(n_reset),
    .target_colour_in(target),
    .target_valid_in(valid),
    .target_ready_out(ready),
    .abort_in(abort),
    .colour_out(colour),
    .busy_out(busy),
    .done_out(done),
    .state_dbg_out(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected colour changes {cycle, value}, done cycles, literal checkpoints.
  logic [39:0] exp_q[$];
  logic [31:0] exp_done_q[$];
  logic [39:0] lit_q[$];

  int vectors = 0;
  int miscompares = 0;
  int timeouts = 0;
  int busy_from = 0;
  int busy_to = 0;
  int m_col = 0, m_start = 0, m_tgt = 0, m_e = 0, m_n = 0;
  logic mon_en = 1'b0, mon_armed = 1'b0, end_req = 1'b0, end_ack = 1'b0;
  logic [7:0]  prev_col = 8'h00;
  logic [39:0] mon_e;
  logic        exp_busy;

  function automatic int model_col(int s, int t, int k);
    int c;
    if (t > s) begin
      c = s + k * STEP;
      if (c > t) c = t;
    end else if (t < s) begin
      c = s - k * STEP;
      if (c < t) c = t;
    end else begin
      c = s;
    end
    return c;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (!mon_armed) begin
        prev_col  = colour;
        mon_armed = 1'b1;
      end
      while (exp_q.size() > 0 && int'(exp_q[0][39:8]) < cyc) begin
        vectors++; miscompares++;
        $display("FAIL colour_missed cycle=%0d actual=%02h required=%02h", cyc, colour, exp_q[0][7:0]);
        void'(exp_q.pop_front());
      end
      if (colour != prev_col) begin
        vectors++;
        if (exp_q.size() > 0 && int'(exp_q[0][39:8]) == cyc) begin
          mon_e = exp_q.pop_front();
          if (colour != mon_e[7:0]) begin
            miscompares++;
            $display("FAIL colour_step cycle=%0d actual=%02h required=%02h", cyc, colour, mon_e[7:0]);
          end
        end else begin
          miscompares++;
          $display("FAIL colour_unexpected cycle=%0d actual=%02h required=%02h", cyc, colour, prev_col);
        end
      end
      prev_col = colour;

      while (exp_done_q.size() > 0 && int'(exp_done_q[0]) < cyc) begin
        vectors++; miscompares++;
        $display("FAIL done_missed cycle=%0d actual=0 required=1 at %0d", cyc, exp_done_q[0]);
        void'(exp_done_q.pop_front());
      end
      if (done) begin
        vectors++;
        if (exp_done_q.size() > 0 && int'(exp_done_q[0]) == cyc) begin
          void'(exp_done_q.pop_front());
        end else begin
          miscompares++;
          $display("FAIL done_unexpected cycle=%0d actual=1 required=0", cyc);
        end
      end

      exp_busy = (cyc >= busy_from) && (cyc < busy_to);
      vectors++;
      if (busy !== exp_busy || ready !== !exp_busy || ((state_dbg != 2'd0) !== exp_busy)) begin
        miscompares++;
        $display("FAIL busy_ready cycle=%0d actual busy=%0b ready=%0b state=%0d required busy=%0b",
                 cyc, busy, ready, state_dbg, exp_busy);
      end

      while (lit_q.size() > 0 && int'(lit_q[0][39:8]) <= cyc) begin
        mon_e = lit_q.pop_front();
        vectors++;
        if (int'(mon_e[39:8]) != cyc || colour != mon_e[7:0]) begin
          miscompares++;
          $display("FAIL colour_literal cycle=%0d actual=%02h required=%02h at %0d",
                   cyc, colour, mon_e[7:0], mon_e[39:8]);
        end
      end

      if (end_req && !end_ack) begin
        vectors++;
        if (exp_q.size() != 0 || exp_done_q.size() != 0 || lit_q.size() != 0 || timeouts != 0) begin
          miscompares++;
          $display("FAIL end_drain actual colour_q=%0d done_q=%0d lit_q=%0d timeouts=%0d required all 0",
                   exp_q.size(), exp_done_q.size(), lit_q.size(), timeouts);
        end
        end_ack = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_lit(input int c, input logic [7:0] v);
    logic [31:0] cc;
    cc = c;
    lit_q.push_back({cc, v});
  endtask

  task automatic truncate(input int a);
    while (exp_q.size() > 0 && int'(exp_q[$][39:8]) >= a) void'(exp_q.pop_back());
    while (exp_done_q.size() > 0 && int'(exp_done_q[$]) >= a) void'(exp_done_q.pop_back());
  endtask

  task automatic send(input logic [7:0] t, input bit with_abort, output int e);
    int guard, d, c;
    logic [31:0] ec;
    logic [7:0]  cv;
    guard = 0;
    while (!(ready === 1'b1 && done === 1'b0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      timeouts++;
      $display("FAIL send_wait actual ready=%0b required 1", ready);
    end
    valid  = 1'b1;
    target = t;
    abort  = with_abort;
    e = cyc + 1;
    d = int'(t) - m_col;
    if (d < 0) d = -d;
    m_n = (d + STEP - 1) / STEP;
    for (int k = 1; k <= m_n; k++) begin
      c  = model_col(m_col, int'(t), k);
      ec = e + STEP_CNT * k;
      cv = c[7:0];
      exp_q.push_back({ec, cv});
    end
    ec = e + STEP_CNT * m_n;
    exp_done_q.push_back(ec);
    busy_from = e;
    busy_to   = e + STEP_CNT * m_n;
    m_start   = m_col;
    m_tgt     = int'(t);
    m_e       = e;
    m_col     = int'(t);
    @(negedge clk);
    valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input bit junk);
    int guard;
    guard = 0;
    while (!(ready === 1'b1 && done === 1'b0) && guard < 2000) begin
      if (junk && cyc < busy_to && $urandom_range(0, 3) == 0) begin
        valid  = 1'b1;
        target = 8'($urandom_range(0, 255));
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    valid = 1'b0;
    if (guard >= 2000) begin
      timeouts++;
      $display("FAIL idle_wait actual ready=%0b done=%0b required ready=1 done=0", ready, done);
    end
  endtask

  task automatic wait_cycle(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      timeouts++;
      $display("FAIL cycle_wait actual=%0d required=%0d", cyc, c);
    end
  endtask

  // Abort sampled on edge a: steps landing on or after a never happen.
  task automatic do_abort(input int a);
    wait_cycle(a - 1);
    abort = 1'b1;
    truncate(a);
    m_col   = model_col(m_start, m_tgt, (a - 1 - m_e) / STEP_CNT);
    busy_to = a;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic do_reset_mid(input int r);
    logic [31:0] rc;
    wait_cycle(r - 1);
    n_reset = 1'b0;
    truncate(r);
    if (model_col(m_start, m_tgt, (r - 1 - m_e) / STEP_CNT) != 0) begin
      rc = r;
      exp_q.push_back({rc, 8'h00});
    end
    m_col = 0;
    if (busy_to > r) busy_to = r;
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e, a, tt;
    bit ab;
    n_reset = 1'b0;
    target  = 8'h00;
    valid   = 1'b0;
    abort   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    mon_en  = 1'b1;
    push_lit(cyc + 1, 8'h00);
    repeat (20) @(negedge clk);

    // fade up 0x00 -> 0x40
    send(8'h40, 1'b0, e);
    push_lit(e + 4, 8'h10); push_lit(e + 8, 8'h20);
    push_lit(e + 12, 8'h30); push_lit(e + 16, 8'h40);
    wait_idle(1'b0);

    // clamp up, then down without wrap, then top-end clamp
    send(8'h45, 1'b0, e);
    push_lit(e + 4, 8'h45);
    wait_idle(1'b0);
    send(8'h00, 1'b0, e);
    push_lit(e + 4, 8'h35); push_lit(e + 8, 8'h25); push_lit(e + 12, 8'h15);
    push_lit(e + 16, 8'h05); push_lit(e + 20, 8'h00);
    wait_idle(1'b0);
    send(8'hF8, 1'b0, e);
    wait_idle(1'b0);
    send(8'hFF, 1'b0, e);
    push_lit(e + 4, 8'hFF);
    wait_idle(1'b0);

    // back to 0, then equal target
    send(8'h00, 1'b0, e);
    wait_idle(1'b0);
    send(8'h00, 1'b0, e);
    push_lit(e + 1, 8'h00);
    wait_idle(1'b0);

    // busy requests ignored, abort on the second step boundary
    send(8'h80, 1'b0, e);
    for (int i = 0; i < 7; i++) begin
      valid  = 1'b1;
      target = 8'h10;
      @(negedge clk);
    end
    valid = 1'b0;
    do_abort(e + 8);
    push_lit(e + 9, 8'h10);
    wait_idle(1'b0);
    send(8'h10, 1'b0, e);
    push_lit(e + 1, 8'h10);
    wait_idle(1'b0);

    // reset in mid-fade, then a clean restart
    send(8'h00, 1'b0, e);
    wait_idle(1'b0);
    send(8'hF0, 1'b0, e);
    do_reset_mid(e + 6);
    push_lit(e + 7, 8'h00);
    wait_idle(1'b0);
    send(8'h20, 1'b0, e);
    push_lit(e + 4, 8'h10); push_lit(e + 8, 8'h20);
    wait_idle(1'b0);

    // randomised traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0:       tt = m_col;
        1, 2:    tt = m_col + $urandom_range(0, 40) - 20;
        default: tt = $urandom_range(0, 255);
      endcase
      if (tt < 0) tt = 0;
      if (tt > 255) tt = 255;
      ab = ($urandom_range(0, 5) == 0);
      send(8'(tt), ab, e);
      if (m_n > 0 && $urandom_range(0, 3) == 0) begin
        a = e + $urandom_range(1, STEP_CNT * m_n);
        do_abort(a);
        wait_idle(1'b0);
      end else if (m_n > 0 && $urandom_range(0, 14) == 0) begin
        a = e + $urandom_range(1, STEP_CNT * m_n);
        do_reset_mid(a);
        wait_idle(1'b0);
      end else begin
        wait_idle(1'b1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 20 && !end_ack; i++) @(negedge clk);
    if (!end_ack) $display("FAIL end_ack actual=0 required=1");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/colour_fader.md
Name: colour_fader

Overview:
Upstream feeder for the per-channel PWM stage. Accepts a target colour through a valid/ready handshake and ramps its registered colour output toward that target in fixed steps at a fixed step rate, so LED brightness changes smoothly instead of jumping. One instance per colour channel; colour_out connects directly to the PWM stage's colour input.

Parameters:
SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz
FADE_STEP_HZ, 1_000, colour steps per second; STEP_COUNTS = SYS_CLK_FREQ / FADE_STEP_HZ (integer division, must be >= 1)
BIT_W, 8, colour width in bits
STEP_SIZE, 1, colour increment per step; legal range 1 .. 2**BIT_W - 1

Ports:
clk_in  input  1  system clock; all logic on its rising edge
n_reset_in  input  1  reset, synchronous, active-low
target_colour_in  input  BIT_W  requested final colour
target_valid_in  input  1  target_colour_in is valid
target_ready_out  output  1  block can accept a new target
abort_in  input  1  stop the current fade and hold the present colour
colour_out  output  BIT_W  current colour, registered; drives the PWM stage
busy_out  output  1  fade in progress
done_out  output  1  one-cycle pulse when a fade completes

Behaviour:
- Reset (n_reset_in low at a rising edge): colour_out=0, busy_out=0, done_out=0, target_ready_out=1, state=IDLE, tick counter=0, target register=0. Reset overrides every other input, including in mid-fade.
- States: IDLE, FADE_UP, FADE_DOWN.
- target_ready_out = 1 only in IDLE. The block accepts a target on a rising edge where target_valid_in && target_ready_out. While busy, target_valid_in is ignored; the upstream must hold the request.
- Acceptance in IDLE: the block latches the target and clears the tick counter.
  - target > colour_out: enter FADE_UP; busy_out=1 and ready=0 on the same edge.
  - target < colour_out: enter FADE_DOWN; same output changes.
  - target == colour_out: stay in IDLE; done_out=1 for exactly the next cycle; busy_out stays 0.
- Tick counter (width $clog2(STEP_COUNTS+1)):
  - In FADE states it counts 0 .. STEP_COUNTS-1.
  - At STEP_COUNTS-1 it wraps to 0 and a step occurs.
  - The first step lands STEP_COUNTS edges after the acceptance edge; later steps follow every STEP_COUNTS cycles.
- Step arithmetic uses BIT_W+1 bits, with no wrap-around:
  - FADE_UP: next = min(colour_out + STEP_SIZE, target).
  - FADE_DOWN: next = max(colour_out - STEP_SIZE, target), with underflow detected before the compare.
- Completion: on the edge where a step makes colour_out == target:
  - state returns to IDLE,
  - busy_out=0, target_ready_out=1,
  - done_out=1 for that one cycle only.
- Total fade time: ceil(|target - start| / STEP_SIZE) * STEP_COUNTS cycles.
- abort_in applies only in FADE states:
  - On the next edge: state=IDLE, colour_out frozen at its current value, tick counter=0, busy=0, ready=1, no done pulse.
  - If an abort coincides with a step edge, the abort wins and no step is applied.
  - In IDLE, abort_in is ignored. If abort_in and an acceptance coincide in IDLE, the acceptance proceeds.
- done_out is never high on two consecutive cycles. In IDLE, colour_out only changes through a fade.
- Elaboration checks: STEP_COUNTS >= 1 and the STEP_SIZE range; either violation is a fatal error.

Test Plan:
Bench params for all scenarios: SYS_CLK_FREQ=100, FADE_STEP_HZ=25 (STEP_COUNTS=4), BIT_W=8, STEP_SIZE=16.
1. Reset: hold n_reset_in low 3 cycles, then release -> colour_out=0x00, ready=1, busy=0, done=0; no change over 20 idle cycles.
2. Fade up: accept 0x40 from 0x00 ->
   - colour_out reads 0x10, 0x20, 0x30, 0x40 at edges 4, 8, 12, 16 after acceptance;
   - busy=1 over edges 1-15;
   - done=1 only in the cycle after edge 16, with ready=1 then.
3. Clamp and no wrap:
   - from 0x40, accept 0x45 -> single step to 0x45 at edge 4 (not 0x50), done pulses;
   - then accept 0x00 -> 0x35, 0x25, 0x15, 0x05, 0x00 at edges 4, 8, 12, 16, 20; no 0xF5.
   - from 0xF8, accept 0xFF -> 0xFF at edge 4, no overflow to 0x08.
4. Equal target: with colour_out=0x00, accept 0x00 -> done=1 for one cycle after the edge, busy never asserts, colour_out stays 0x00.
5. Busy and abort:
   - from 0x00 target 0x80; while busy, drive valid with 0x10 -> ignored (ready=0);
   - assert abort on the edge-8 step boundary -> colour_out stays 0x10, IDLE, no done pulse;
   - a new target 0x10 is then accepted and completes immediately via the equal-target path.
6. Reset mid-fade: during fade 0x00 -> 0xF0, drive n_reset_in low at edge 6 -> colour_out=0x00, busy=0, done=0, ready=1 on that edge; the following fade restarts cleanly.
